ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB slave (responder) that backs a word-organised on-chip RAM. It is the target for system-bus master accesses, including debug-module system bus access (SBA) reads and writes. It decodes address/data-phase pipelining and supports byte, halfword and word transfers with little-endian lanes. It inserts a programmable number of wait states and returns the two-cycle AHB ERROR response for illegal transfers. It sits behind the AHB decoder/mux; HSEL comes from the decoder.

Parameters:
MEM_AW, 10, log2 of RAM depth in 32-bit words (window = 4*2^MEM_AW bytes)
WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..7)

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HSEL  in  1  slave select from decoder
HADDR  in  `AHB_ADDR_WIDTH  byte address
HTRANS  in  2  `IDLE/BUSY/`NONSEQ/SEQ
HWRITE  in  1  1=write
HSIZE  in  3  0=byte,1=half,2=word
HBURST  in  3  ignored (each beat handled independently)
HPROT  in  4  ignored
HWDATA  in  `AHB_DATA_WIDTH  write data (data phase)
HREADY  in  1  global bus ready (mux output)
HREADYOUT  out  1  this slave's ready
HRESP  out  2  00 OKAY, 01 ERROR
HRDATA  out  `AHB_DATA_WIDTH  read data

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK. On reset: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Accept: the address phase is sampled when HSEL && HREADY && HTRANS[1]=1. The block registers addr_r, size_r and write_r.
- IDLE/BUSY transfers, or HSEL=0, or HREADY=0: no capture; the next data phase is zero-wait OKAY.
- Error check (at accept) flags a transfer if any of the following holds:
  - HSIZE>2;
  - misalignment: half with HADDR[0]=1, or word with HADDR[1:0]!=0;
  - out of window: HADDR[`AHB_ADDR_WIDTH-1:MEM_AW+2] nonzero.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=OKAY.
    - Accepted legal transfer: to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES), else to DATA.
    - Accepted illegal transfer: to ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; go to DATA when the counter reaches 1.
  - DATA: HREADYOUT=1, HRESP=OKAY.
    - Write: commit HWDATA lanes to RAM at this cycle's edge.
    - Read: HRDATA valid this cycle.
    - Next state evaluated as in IDLE, since a new accept may occur in this cycle.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. No RAM write. Next state evaluated as in IDLE; a master-issued IDLE leads to IDLE.
- Byte lanes:
  - byte: lane addr_r[1:0];
  - half: lanes {addr_r[1],0}+{1,0};
  - word: all four lanes.
  - Write enables only the selected lanes.
- Reads:
  - HRDATA = full RAM word at addr_r[MEM_AW+1:2], combinational from registered address, during the read DATA cycle. The master extracts lanes.
  - HRDATA=0 in all other cycles.
- Read-after-write to the same word in back-to-back transfers returns the new data; no hazard, since the write commits before the read data phase.
- Pipelined transfers: a write's DATA cycle may overlap the next address phase. Write data is always taken from HWDATA in the DATA cycle, never from the address phase.
- Reset mid-transfer: the pending write is not committed; the FSM returns to IDLE.

Decomposition:
- Shared defines (top_defines.vh): `IDLE/`BUSY/`NONSEQ/`SEQ, HRESP OKAY/ERROR codes, HSIZE codes, `AHB_ADDR_WIDTH, `AHB_DATA_WIDTH.
- FSM state encodings stay local to the module.
- One sub-module: sram_byte_array, a 2^MEM_AW x 32 array with 4 byte write enables, synchronous write and asynchronous read; replaceable by a hard macro.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10, WAIT_STATES=0 -> both OKAY, zero wait; HRDATA=0xDEADBEEF in the read data cycle.
- Byte writes 0x11 @0x21 and half write 0xAABB @0x22 over word 0x00000000 -> word read @0x20 returns 0xAABB1100.
- WAIT_STATES=3, read -> HREADYOUT low exactly 3 cycles, then high with data and OKAY.
- Half access @0x01; HSIZE=3 @0x0; word @0x4000 with MEM_AW=10 -> each returns ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01); RAM unchanged.
- Back-to-back NONSEQ write @0x8 = 0x5 followed immediately by read @0x8, plus HREADY held low by another slave during an address phase -> read returns 0x5; no capture while HREADY=0.
- Assert HRESETn low during a WAIT of a write -> outputs go to reset values immediately; a later read of that address returns the old data.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_pkg
//   Shared AHB constants for the SRAM slave: bus widths, HTRANS / HRESP /
//   HSIZE encodings, and a helper that turns a transfer size and the low
//   address bits into a 4-bit little-endian byte-lane mask.
// ---------------------------------------------------------------------------
package ahb_sram_slave_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Byte lanes touched by a legal transfer. Only called with sizes 0..2 and
  // addresses already checked for alignment.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      2'd0:    mask = 4'b0001 << addr_lo;
      2'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_sram.sv
// ---------------------------------------------------------------------------
// sram_byte_array
//   2^AW x 32-bit RAM with per-byte write enables. Synchronous write,
//   asynchronous read; written so a hard macro can be dropped in its place.
//
//   i_clk    in   clock
//   i_we     in   byte-lane write enables (bit n -> bits 8n+7:8n)
//   i_addr   in   word address
//   i_wdata  in   write data
//   o_rdata  out  word at i_addr (combinational)
// ---------------------------------------------------------------------------
module sram_byte_array
  import ahb_sram_slave_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                      i_clk,
  input  logic [3:0]                i_we,
  input  logic [AW-1:0]             i_addr,
  input  logic [AHB_DATA_WIDTH-1:0] i_wdata,
  output logic [AHB_DATA_WIDTH-1:0] o_rdata
);

  localparam int NBYTES = AHB_DATA_WIDTH / 8;

  logic [AHB_DATA_WIDTH-1:0] r_mem [2**AW];

  // NOTE: the array has no reset branch on purpose; clearing every word would
  // turn it into a flop bank and prevent mapping onto a RAM macro.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB responder in front of a word-organised on-chip RAM. Handles the
//   address/data-phase pipeline, byte/half/word little-endian lanes, a fixed
//   number of wait states per OKAY data phase and the two-cycle ERROR
//   response for oversize, misaligned or out-of-window transfers.
//
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   HSEL            slave select from the decoder
//   HADDR           byte address
//   HTRANS          IDLE/BUSY/NONSEQ/SEQ
//   HWRITE          1 = write
//   HSIZE           0 byte, 1 half, 2 word (larger sizes are errors)
//   HBURST, HPROT   ignored, every beat is handled on its own
//   HWDATA          write data, taken in the data phase
//   HREADY          global bus ready
//   HREADYOUT       this slave's ready
//   HRESP           00 OKAY, 01 ERROR
//   HRDATA          read data, zero outside a read data cycle
// ---------------------------------------------------------------------------
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [3:0]                HPROT,
  input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic [1:0]                HRESP,
  output logic [AHB_DATA_WIDTH-1:0] HRDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  state_e                    r_state;
  state_e                    w_next_state;
  logic [2:0]                r_wait_cnt;
  logic [2:0]                w_next_wait_cnt;
  logic [MEM_AW+1:0]         r_addr;
  logic [1:0]                r_size;
  logic                      r_write;

  logic                      w_accept;
  logic                      w_illegal;
  logic [3:0]                w_we;
  logic [AHB_DATA_WIDTH-1:0] w_rdata;
  logic                      w_unused;

  // Only NONSEQ/SEQ with both select and global ready start a data phase.
  assign w_accept = HSEL & HREADY & HTRANS[1];

  assign w_illegal = (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))
                   | (|HADDR[AHB_ADDR_WIDTH-1:MEM_AW+2]);

  assign w_unused = ^{HBURST, HPROT, HTRANS[0]};

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_write    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if (w_accept) begin
        r_addr  <= HADDR[MEM_AW+1:0];
        r_size  <= HSIZE[1:0];
        r_write <= HWRITE;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    HREADYOUT       = 1'b1;
    HRESP           = HRESP_OKAY;
    HRDATA          = '0;
    w_we            = 4'b0000;

    case (r_state)
      S_WAIT: begin
        HREADYOUT       = 1'b0;
        w_next_wait_cnt = r_wait_cnt - 3'd1;
        if (r_wait_cnt == 3'd1) w_next_state = S_DATA;
      end
      S_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = HRESP_ERROR;
        w_next_state = S_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all complete this cycle, so any of them can
        // overlap the next address phase.
        if (r_state == S_DATA) begin
          if (r_write) w_we   = lane_mask(r_size, r_addr[1:0]);
          else         HRDATA = w_rdata;
        end
        if (r_state == S_ERR2) HRESP = HRESP_ERROR;

        if (!w_accept) begin
          w_next_state = S_IDLE;
        end else if (w_illegal) begin
          w_next_state = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          w_next_state    = S_WAIT;
          w_next_wait_cnt = WAIT_LOAD;
        end else begin
          w_next_state = S_DATA;
        end
      end
    endcase
  end

  sram_byte_array #(
    .AW (MEM_AW)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_addr  (r_addr[MEM_AW+1:2]),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//   Two slaves on one shared address/data bus: dut0 with no wait states,
//   dut1 with three. Expected responses are queued when a transfer is
//   accepted and compared when its data phase completes; a word-level model
//   of RAM contents is updated when a write data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam int MEM_AW = 10;
  localparam int WS0    = 0;
  localparam int WS1    = 3;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_bus;
  logic        hreadyout0, hreadyout1;
  logic [1:0]  hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout_s;
  logic [1:0]  hresp_s;
  logic [31:0] hrdata_s;

  bit          sel;
  bit          stall;

  exp_t        sb[$];
  logic [31:0] model[int];
  bit          dp_valid;
  bit          dp_wr;
  bit          dp_err;
  logic [2:0]  dp_sz;
  logic [31:0] dp_addr;
  logic [31:0] dp_wdata;
  int          dp_key;
  int          dp_waits;

  int          n_vec;
  int          n_err;
  string       step;

  assign hready_bus  = stall ? 1'b0 : (sel ? hreadyout1 : hreadyout0);
  assign hreadyout_s = sel ? hreadyout1 : hreadyout0;
  assign hresp_s     = sel ? hresp1 : hresp0;
  assign hrdata_s    = sel ? hrdata1 : hrdata0;

  ahb_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(WS0)) u_dut0 (
    .HCLK      (hclk),
    .HRESETn   (hresetn),
    .HSEL      (hsel & ~sel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (3'b000),
    .HPROT     (4'b0011),
    .HWDATA    (hwdata),
    .HREADY    (hready_bus),
    .HREADYOUT (hreadyout0),
    .HRESP     (hresp0),
    .HRDATA    (hrdata0)
  );

  ahb_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(WS1)) u_dut1 (
    .HCLK      (hclk),
    .HRESETn   (hresetn),
    .HSEL      (hsel & sel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (3'b000),
    .HPROT     (4'b0011),
    .HWDATA    (hwdata),
    .HREADY    (hready_bus),
    .HREADYOUT (hreadyout1),
    .HRESP     (hresp1),
    .HRDATA    (hrdata1)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
    end
  endtask

  // Merge the completed write's lanes into the model word.
  task automatic commit_write();
    logic [31:0] w;
    int          base;
    w    = model.exists(dp_key) ? model[dp_key] : 32'h0;
    base = (dp_sz == 3'd0) ? int'(dp_addr[1:0]) :
           (dp_sz == 3'd1) ? 2 * int'(dp_addr[1]) : 0;
    for (int i = 0; i < (1 << dp_sz); i++) begin
      w[8*(base+i) +: 8] = dp_wdata[8*(base+i) +: 8];
    end
    model[dp_key] = w;
  endtask

  // Called at the falling edge of every bus cycle.
  task automatic data_phase_check();
    exp_t e;
    if (!dp_valid) begin
      check("idle_ready", 32'(hreadyout_s), 32'd1);
      check("idle_resp",  32'(hresp_s),     32'd0);
      check("idle_rdata", hrdata_s,         32'd0);
    end else begin
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        if (hreadyout_s !== 1'b1) begin
          e = sb[0];
          dp_waits++;
          check("stall_resp",  32'(hresp_s), 32'(e.resp));
          check("stall_rdata", hrdata_s,     32'd0);
        end else begin
          e = sb.pop_front();
          check("resp",  32'(hresp_s),  32'(e.resp));
          check("rdata", hrdata_s,      e.rdata);
          check("waits", 32'(dp_waits), 32'(e.waits));
          if (dp_wr && !dp_err) commit_write();
        end
      end
    end
  endtask

  task automatic accept(input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit   err;
    int   key;
    err = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00)
       || ((a >> (MEM_AW + 2)) != 0);
    key     = (int'(sel) << 16) + int'(a[MEM_AW+1:2]);
    e.resp  = err ? 2'b01 : 2'b00;
    e.waits = err ? 1 : (sel ? WS1 : WS0);
    e.rdata = (!err && !wr && model.exists(key)) ? model[key] : 32'h0;
    sb.push_back(e);
    dp_valid = 1'b1;
    dp_wr    = wr;
    dp_err   = err;
    dp_sz    = sz;
    dp_addr  = a;
    dp_wdata = wd;
    dp_key   = key;
    dp_waits = 0;
  endtask

  // One address phase (act=1) or an IDLE slot (act=0), held until HREADY.
  // Entered and left one time unit after a rising edge.
  task automatic xfer(input bit act, input bit wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    bit ready_now;
    bit done;
    done = 1'b0;
    for (int guard = 0; guard < 16 && !done; guard++) begin
      hsel   = act;
      htrans = act ? 2'b10 : 2'b00;
      hwrite = wr;
      hsize  = sz;
      haddr  = a;
      hwdata = dp_valid ? dp_wdata : (32'hBAD0_0000 ^ a);
      @(negedge hclk);
      ready_now = hready_bus;
      data_phase_check();
      @(posedge hclk);
      #1;
      if (ready_now) begin
        if (act) accept(wr, sz, a, wd);
        else     dp_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) check("bus_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    sel     = 1'b0;
    stall   = 1'b0;
    hsel    = 1'b0;
    haddr   = '0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'd0;
    hwdata  = '0;
    dp_valid = 1'b0;
    hresetn = 1'b0;

    step = "reset";
    repeat (2) @(posedge hclk);
    #2;
    check("rdy0",  32'(hreadyout0), 32'd1);
    check("resp0", 32'(hresp0),     32'd0);
    check("data0", hrdata0,         32'd0);
    check("rdy1",  32'(hreadyout1), 32'd1);
    check("resp1", 32'(hresp1),     32'd0);
    check("data1", hrdata1,         32'd0);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    step = "word_rw";
    xfer(1, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    xfer(1, 0, 3'd2, 32'h10, 32'h0);
    xfer(0, 0, 3'd0, 32'h0,  32'h0);

    step = "lanes";
    xfer(1, 1, 3'd2, 32'h20, 32'h0000_0000);
    xfer(1, 1, 3'd0, 32'h21, 32'h0000_1100);
    xfer(1, 1, 3'd1, 32'h22, 32'hAABB_0000);
    xfer(1, 0, 3'd2, 32'h20, 32'h0);
    xfer(1, 0, 3'd0, 32'h23, 32'h0);
    xfer(0, 0, 3'd0, 32'h0,  32'h0);

    step = "errors";
    xfer(1, 1, 3'd2, 32'h0,    32'h0123_4567);
    xfer(1, 1, 3'd1, 32'h1,    32'hFFFF_FFFF);
    xfer(1, 1, 3'd3, 32'h0,    32'hFFFF_FFFF);
    xfer(1, 1, 3'd2, 32'h4000, 32'hFFFF_FFFF);
    xfer(1, 0, 3'd2, 32'h4000, 32'h0);
    xfer(1, 0, 3'd2, 32'h0,    32'h0);
    xfer(0, 0, 3'd0, 32'h0,    32'h0);

    step = "b2b";
    xfer(1, 1, 3'd2, 32'h8, 32'h0000_0005);
    xfer(1, 0, 3'd2, 32'h8, 32'h0);
    xfer(0, 0, 3'd0, 32'h0, 32'h0);

    step = "hready_low";
    stall  = 1'b1;
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b0;
    hsize  = 3'd2;
    haddr  = 32'h8;
    repeat (2) begin
      @(negedge hclk);
      data_phase_check();
      @(posedge hclk);
      #1;
    end
    stall = 1'b0;
    xfer(0, 0, 3'd0, 32'h0, 32'h0);
    xfer(1, 0, 3'd2, 32'h8, 32'h0);
    xfer(0, 0, 3'd0, 32'h0, 32'h0);

    step = "wait3";
    sel = 1'b1;
    xfer(1, 1, 3'd2, 32'h40, 32'h55AA_33CC);
    xfer(1, 0, 3'd2, 32'h40, 32'h0);
    xfer(1, 1, 3'd3, 32'h40, 32'h0);
    xfer(0, 0, 3'd0, 32'h0,  32'h0);

    step = "reset_mid";
    xfer(1, 1, 3'd2, 32'h30, 32'h1234_5678);
    xfer(0, 0, 3'd0, 32'h0,  32'h0);
    xfer(1, 1, 3'd2, 32'h30, 32'hCAFE_F00D);
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    check("in_wait", 32'(hreadyout1), 32'd0);
    #1;
    hresetn = 1'b0;
    #1;
    check("rst_rdy",  32'(hreadyout1), 32'd1);
    check("rst_resp", 32'(hresp1),     32'd0);
    check("rst_data", hrdata1,         32'd0);
    sb.delete();
    dp_valid = 1'b0;
    repeat (2) @(posedge hclk);
    #3;
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    xfer(0, 0, 3'd0, 32'h0,  32'h0);
    xfer(1, 0, 3'd2, 32'h30, 32'h0);
    xfer(0, 0, 3'd0, 32'h0,  32'h0);

    step = "end";
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
